// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks the PC through memory one request at a time,
// holds each fetched instruction for the consumer, handles redirects and fetch timeouts.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fault
);

  // Handshake: a request is outstanding on every cycle imem_req=1 and completes on the
  // cycle imem_ack=1; an instruction is consumed on a cycle with instr_valid=1 and stall=0.

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [31:0] TMO = 32'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        pend_valid_q, pend_valid_d;

  logic [31:0] redirect_tgt;
  logic        timeout_hit;

  assign redirect_tgt = {redirect_addr[31:2], 2'b00};
  // The current FETCH cycle is the TIMEOUT-th one without an ack.
  assign timeout_hit  = (TMO != 32'd0) && ((wait_cnt_q + 32'd1) >= TMO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VEC;
      instr_q      <= 32'd0;
      instr_pc_q   <= 32'd0;
      wait_cnt_q   <= 32'd0;
      pend_addr_q  <= 32'd0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      wait_cnt_q   <= wait_cnt_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    wait_cnt_d   = wait_cnt_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (imem_ack) begin
          wait_cnt_d = 32'd0;
          if (redirect_valid) begin
            // Data belongs to the abandoned path; restart at the new target.
            pc_d         = redirect_tgt;
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            pc_d         = pend_addr_q;
            pend_valid_d = 1'b0;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = ST_HOLD;
          end
        end else if (timeout_hit) begin
          state_d      = ST_FAULT;
          wait_cnt_d   = 32'd0;
          pend_valid_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
          if (redirect_valid) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = redirect_tgt;
          end
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = ST_FETCH;
        end else if (!stall) begin
          state_d = ST_FETCH;
        end
      end

      ST_FAULT: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: scenario tasks drive the memory side and consumer,
// a queue of expected {pc, instr} pairs is checked as instructions are consumed.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_pc = RESET_VEC;
  logic [63:0] exp_q[$];

  fetch_ctrl #(.RESET_VEC(RESET_VEC), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .fault(fault)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_pc = RESET_VEC;
    exp_q.delete();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_req: imem_req=%b required 1 within 20 cycles", tag, imem_req);
    end
  endtask

  task automatic fetch_one(input logic [31:0] data, input int delay, input string tag);
    wait_req(tag);
    checks++;
    if (imem_addr !== model_pc) begin
      errors++;
      $display("FAIL %s imem_addr: got %h required %h", tag, imem_addr, model_pc);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
        errors++;
        $display("FAIL %s addr_stable: req=%b addr=%h required 1/%h", tag, imem_req, imem_addr, model_pc);
      end
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    exp_q.push_back({model_pc, data});
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    model_pc = model_pc + 32'd4;
  endtask

  // Scoreboard pop: called on the cycle the instruction should first be visible.
  task automatic consume(input int stall_cycles, input string tag);
    logic [63:0] exp;
    checks++;
    if (instr_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s instr_valid: got %b required 1 (queue depth %0d)", tag, instr_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if ({instr_pc, instr} !== exp) begin
        errors++;
        $display("FAIL %s instr: got pc=%h instr=%h required pc=%h instr=%h",
                 tag, instr_pc, instr, exp[63:32], exp[31:0]);
      end
      for (int i = 0; i < stall_cycles; i++) begin
        stall = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || {instr_pc, instr} !== exp) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b req=%b pc=%h instr=%h required 1/0/%h/%h",
                   tag, instr_valid, imem_req, instr_pc, instr, exp[63:32], exp[31:0]);
        end
      end
      stall = 1'b0;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== model_pc) begin
        errors++;
        $display("FAIL %s after_consume: valid=%b req=%b addr=%h required 0/1/%h",
                 tag, instr_valid, imem_req, imem_addr, model_pc);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0 ||
        imem_addr !== RESET_VEC || instr !== 32'd0 || instr_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: req=%b valid=%b fault=%b addr=%h instr=%h pc=%h required 0/0/0/%h/0/0",
               imem_req, instr_valid, fault, imem_addr, instr, instr_pc, RESET_VEC);
    end
    reset = 1'b0;
    model_pc = RESET_VEC;
    fetch_one(32'h1111_2222, 0, "reset_pre");
    // Now in HOLD: reset must abort without waiting for a clock edge.
    reset = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'd0 || imem_addr !== RESET_VEC) begin
      errors++;
      $display("FAIL async_reset: valid=%b instr=%h addr=%h required 0/0/%h",
               instr_valid, instr, imem_addr, RESET_VEC);
    end
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'd0 || imem_req !== 1'b1 || imem_addr !== RESET_VEC) begin
      errors++;
      $display("FAIL late_ack_boot: valid=%b instr=%h req=%b addr=%h required 0/0/1/%h",
               instr_valid, instr, imem_req, imem_addr, RESET_VEC);
    end
    exp_q.delete();
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fetch_one(model_pc, 0, "seq");
      consume(0, "seq");
    end
  endtask

  task automatic test_stall();
    do_reset();
    fetch_one(32'hA5A5_0001, 0, "stall");
    consume(3, "stall");
  endtask

  task automatic test_redirect_fetch();
    do_reset();
    fetch_one(32'h0000_0013, 0, "rdf_pre");
    consume(0, "rdf_pre");
    // Redirect while 80000004 is outstanding; ack arrives two cycles later.
    redirect_valid = 1'b1;
    redirect_addr = 32'h8000_1003;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0004 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdf_req_unchanged: req=%b addr=%h valid=%b required 1/80000004/0",
               imem_req, imem_addr, instr_valid);
    end
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_1000) begin
      errors++;
      $display("FAIL rdf_discard: valid=%b req=%b addr=%h required 0/1/80001000",
               instr_valid, imem_req, imem_addr);
    end
    // Pending 80003000, then a redirect to 80004000 arriving with the ack wins.
    redirect_valid = 1'b1;
    redirect_addr = 32'h8000_3000;
    @(negedge clk);
    redirect_addr = 32'h8000_4000;
    imem_ack = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_4000) begin
      errors++;
      $display("FAIL rdf_priority: valid=%b req=%b addr=%h required 0/1/80004000",
               instr_valid, imem_req, imem_addr);
    end
    model_pc = 32'h8000_4000;
    fetch_one(32'hC0DE_0001, 1, "rdf_post");
    consume(1, "rdf_post");
  endtask

  task automatic test_redirect_hold();
    do_reset();
    fetch_one(32'h0BAD_F00D, 0, "rdh");
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL rdh_valid: got %b required 1", instr_valid);
    end
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 32'h8000_2000;
    @(negedge clk);
    redirect_valid = 1'b0;
    stall = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_2000) begin
      errors++;
      $display("FAIL rdh_drop: valid=%b req=%b addr=%h required 0/1/80002000",
               instr_valid, imem_req, imem_addr);
    end
    void'(exp_q.pop_front());
    model_pc = 32'h8000_2000;
    fetch_one(32'h2000_0001, 0, "rdh_post");
    consume(0, "rdh_post");
  endtask

  task automatic test_timeout();
    do_reset();
    wait_req("tmo");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || fault !== 1'b0) begin
        errors++;
        $display("FAIL tmo_wait cycle %0d: req=%b fault=%b required 1/0", i, imem_req, fault);
      end
      @(negedge clk);
    end
    checks++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_fault: fault=%b req=%b valid=%b required 1/0/0", fault, imem_req, instr_valid);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (fault !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_ack_ignored: fault=%b valid=%b required 1/0", fault, instr_valid);
    end
    redirect_valid = 1'b1;
    redirect_addr = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_0100) begin
      errors++;
      $display("FAIL tmo_recover: fault=%b req=%b addr=%h required 0/1/80000100", fault, imem_req, imem_addr);
    end
    model_pc = 32'h8000_0100;
    fetch_one(32'h0100_0001, 2, "tmo_post");
    consume(0, "tmo_post");
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_one(32'h0000_0001, 0, "wrap_pre");
    redirect_valid = 1'b1;
    redirect_addr = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    void'(exp_q.pop_front());
    model_pc = 32'hFFFF_FFFC;
    fetch_one(32'hFFFF_0001, 0, "wrap");
    consume(0, "wrap");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      fetch_one($urandom, $urandom_range(0, 2), "b2b");
      consume($urandom_range(0, 3), "b2b");
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: queue depth %0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_fetch();
    test_redirect_hold();
    test_timeout();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
